// File: rtl/sm_pwm_multichannel_gen.sv
// sm_pwm_multichannel_gen
//   Multi-channel PWM generator: one clock-enable prescaler and one shared
//   period counter drive NUM_CH compare channels. Period, duty and polarity
//   pass through shadow registers that update only at a frame boundary (or
//   continuously while idle), so the outputs never glitch mid-frame.
//
// Ports
//   clk          system clock, all logic on posedge
//   rst_n        asynchronous active-low reset
//   en           run enable
//   period       counts per PWM frame (0 is treated as 1)
//   duty         per-channel duty, channel i = duty[i*CNT_W +: CNT_W]
//   pol          per-channel polarity, 1 = inverted output
//   pwm_out      registered PWM outputs
//   frame_start  one-clk pulse when the counter (re)starts at 0
module sm_pwm_multichannel_gen #(
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 8,
    parameter int PRESCALE = 100
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [CNT_W-1:0]        period,
    input  logic [NUM_CH*CNT_W-1:0] duty,
    input  logic [NUM_CH-1:0]       pol,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    frame_start
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]           presc, presc_next;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic [CNT_W-1:0]        period_sh, period_sh_next;
    logic [NUM_CH*CNT_W-1:0] duty_sh, duty_sh_next;
    logic [NUM_CH-1:0]       pol_sh, pol_sh_next;
    logic [NUM_CH-1:0]       pwm_next;
    logic                    en_q;

    logic [CNT_W-1:0] eff_per;
    logic             start, run, tick, wrap, load;

    // The en-rise edge is itself the frame-start edge: presc and cnt stay at 0
    // on it, so the first frame is a full eff_per*PRESCALE clks even when
    // PRESCALE=1.
    always_comb begin
        eff_per = (period_sh == '0) ? CNT_W'(1) : period_sh;
        start   = en && !en_q;
        run     = en && en_q;
        tick    = run && (presc == PRESC_LAST);
        wrap    = tick && (cnt >= eff_per - CNT_W'(1));
        load    = wrap || !en;
    end

    always_comb begin
        presc_next     = '0;
        cnt_next       = '0;
        period_sh_next = period_sh;
        duty_sh_next   = duty_sh;
        pol_sh_next    = pol_sh;
        pwm_next       = '0;

        if (run && !tick) begin
            presc_next = presc + PW'(1);
        end

        if (run && !wrap) begin
            cnt_next = tick ? cnt + CNT_W'(1) : cnt;
        end

        if (load) begin
            period_sh_next = period;
            duty_sh_next   = duty;
            pol_sh_next    = pol;
        end

        // Compare uses post-update counter and shadows so pwm_out lines up
        // with cnt without an extra cycle of latency.
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!en) begin
                pwm_next[i] = pol_sh_next[i];
            end else begin
                pwm_next[i] = (cnt_next < duty_sh_next[i*CNT_W +: CNT_W]) ^ pol_sh_next[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc       <= '0;
            cnt         <= '0;
            period_sh   <= '0;
            duty_sh     <= '0;
            pol_sh      <= '0;
            en_q        <= 1'b0;
            pwm_out     <= '0;
            frame_start <= 1'b0;
        end else begin
            presc       <= presc_next;
            cnt         <= cnt_next;
            period_sh   <= period_sh_next;
            duty_sh     <= duty_sh_next;
            pol_sh      <= pol_sh_next;
            en_q        <= en;
            pwm_out     <= pwm_next;
            frame_start <= wrap || start;
        end
    end

endmodule

// File: tb/tb_sm_pwm_multichannel_gen.sv
module tb_sm_pwm_multichannel_gen;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [7:0]  period;
    logic [15:0] duty;
    logic [1:0]  pol;
    logic [1:0]  pwm_o [2];
    logic        fs_o  [2];

    int checks = 0;
    int errors = 0;

    // Instance 0 uses PRESCALE=1, instance 1 uses PRESCALE=4.
    sm_pwm_multichannel_gen #(.NUM_CH(2), .CNT_W(8), .PRESCALE(1)) dut_p1 (
        .clk(clk), .rst_n(rst_n), .en(en), .period(period), .duty(duty),
        .pol(pol), .pwm_out(pwm_o[0]), .frame_start(fs_o[0])
    );

    sm_pwm_multichannel_gen #(.NUM_CH(2), .CNT_W(8), .PRESCALE(4)) dut_p4 (
        .clk(clk), .rst_n(rst_n), .en(en), .period(period), .duty(duty),
        .pol(pol), .pwm_out(pwm_o[1]), .frame_start(fs_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a frame is eff_per*P clks long; the counter value is
    // simply the elapsed clks in the frame divided by P.
    int          mp [2] = '{1, 4};
    bit          m_run  [2];
    int          m_t    [2];
    int          m_per  [2];
    logic [15:0] m_duty [2];
    logic [1:0]  m_pol  [2];
    logic [1:0]  m_out  [2];
    logic        m_fs   [2];

    function automatic logic [1:0] level(input int c, input logic [15:0] d, input logic [1:0] p);
        logic [1:0] r;
        for (int ch = 0; ch < 2; ch++) begin
            r[ch] = (c < int'((d >> (8 * ch)) & 16'hff)) ^ p[ch];
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            int          nt;
            int          eff;
            logic [15:0] nd;
            logic [1:0]  np;
            int          nper;
            if (!rst_n) begin
                m_run[k] <= 1'b0; m_t[k] <= 0; m_per[k] <= 0;
                m_duty[k] <= '0; m_pol[k] <= '0; m_out[k] <= '0; m_fs[k] <= 1'b0;
            end else if (!en) begin
                m_run[k] <= 1'b0; m_t[k] <= 0; m_per[k] <= int'(period);
                m_duty[k] <= duty; m_pol[k] <= pol; m_out[k] <= pol; m_fs[k] <= 1'b0;
            end else if (!m_run[k]) begin
                m_run[k] <= 1'b1; m_t[k] <= 0; m_fs[k] <= 1'b1;
                m_out[k] <= level(0, m_duty[k], m_pol[k]);
            end else begin
                eff  = (m_per[k] == 0) ? 1 : m_per[k];
                nt   = m_t[k] + 1;
                nd   = m_duty[k];
                np   = m_pol[k];
                nper = m_per[k];
                if (nt == eff * mp[k]) begin
                    nt = 0; nd = duty; np = pol; nper = int'(period);
                    m_fs[k] <= 1'b1;
                end else begin
                    m_fs[k] <= 1'b0;
                end
                m_t[k] <= nt; m_duty[k] <= nd; m_pol[k] <= np; m_per[k] <= nper;
                m_out[k] <= level(nt / mp[k], nd, np);
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (pwm_o[k] !== m_out[k] || fs_o[k] !== m_fs[k]) begin
                errors++;
                $display("FAIL model_cmp inst%0d t=%0t pwm=%b fs=%b expected pwm=%b fs=%b",
                         k, $time, pwm_o[k], fs_o[k], m_out[k], m_fs[k]);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_fs(input int k);
        int n = 0;
        @(negedge clk);
        while (fs_o[k] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (fs_o[k] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_fs_timeout inst%0d got no pulse expected pulse", k);
        end
    endtask

    task automatic window(input int k, input int n, output int h0, output int h1, output int f);
        h0 = 0; h1 = 0; f = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            h0 += int'(pwm_o[k][0]);
            h1 += int'(pwm_o[k][1]);
            f  += int'(fs_o[k]);
        end
    endtask

    int h0, h1, f, ha, hb;
    int d_tab  [3] = '{0, 10, 255};
    int ea_tab [3] = '{0, 10, 10};
    int eb_tab [3] = '{0, 40, 40};

    initial begin
        rst_n = 1'b0; en = 1'b0; period = 8'd10; duty = {8'd7, 8'd3}; pol = 2'b00;
        repeat (3) @(negedge clk);
        chk("reset_pwm0", int'(pwm_o[0]), 0);
        chk("reset_fs1", int'(fs_o[1]), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_pwm0", int'(pwm_o[0]), 0);
        en = 1'b1;
        @(negedge clk);
        chk("en_rise_fs0", int'(fs_o[0]), 1);
        chk("en_rise_fs1", int'(fs_o[1]), 1);

        // Basic duty pattern, both prescales.
        wait_fs(0); window(0, 10, h0, h1, f);
        chk("t1_p1_ch0", h0, 3); chk("t1_p1_ch1", h1, 7); chk("t1_p1_fs", f, 1);
        wait_fs(1); window(1, 40, h0, h1, f);
        chk("t1_p4_ch0", h0, 12); chk("t1_p4_ch1", h1, 28); chk("t1_p4_fs", f, 1);

        // Duty boundaries: 0%, exactly period, above period.
        for (int j = 0; j < 3; j++) begin
            duty[7:0] = 8'(d_tab[j]);
            wait_fs(0); window(0, 10, h0, h1, f);
            chk("t2_p1_ch0", h0, ea_tab[j]); chk("t2_p1_fs", f, 1);
            wait_fs(1); window(1, 40, h0, h1, f);
            chk("t2_p4_ch0", h0, eb_tab[j]); chk("t2_p4_fs", f, 1);
        end

        // Mid-frame duty change lands only in the next frame.
        duty[7:0] = 8'd3;
        wait_fs(0); wait_fs(0);
        ha = 0; hb = 0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            if (i < 10) ha += int'(pwm_o[0][0]);
            else        hb += int'(pwm_o[0][0]);
            if (i == 5) duty[7:0] = 8'd8;
        end
        chk("t3_old_frame", ha, 3);
        chk("t3_new_frame", hb, 8);

        // Inverted channel 0, then abort mid-frame.
        duty = {8'd7, 8'd3}; pol = 2'b01;
        wait_fs(0); window(0, 10, h0, h1, f);
        chk("t4_inv_ch0", h0, 7); chk("t4_ch1", h1, 7);
        wait_fs(0);
        repeat (4) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("t4_abort_pwm0", int'(pwm_o[0]), 1);
        chk("t4_abort_pwm1", int'(pwm_o[1]), 1);
        chk("t4_abort_fs0", int'(fs_o[0]), 0);

        // Prescaled frame.
        period = 8'd5; duty = {8'd7, 8'd2}; pol = 2'b00;
        @(negedge clk);
        en = 1'b1;
        wait_fs(1); window(1, 20, h0, h1, f);
        chk("t5_p4_ch0", h0, 8); chk("t5_p4_ch1", h1, 20); chk("t5_p4_fs", f, 1);
        @(negedge clk);
        chk("t5_p4_spacing", int'(fs_o[1]), 1);
        wait_fs(0); window(0, 5, h0, h1, f);
        chk("t5_p1_ch0", h0, 2); chk("t5_p1_fs", f, 1);

        // Asynchronous reset between edges.
        wait_fs(0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_pwm0", int'(pwm_o[0]), 0);
        chk("t6_async_pwm1", int'(pwm_o[1]), 0);
        chk("t6_async_fs0", int'(fs_o[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_restart_fs0", int'(fs_o[0]), 1);
        chk("t6_restart_fs1", int'(fs_o[1]), 1);

        // Randomised run against the model.
        for (int c = 0; c < 5000; c++) begin
            int r;
            @(negedge clk);
            r = int'($urandom_range(0, 999));
            if (r < 60) begin
                case ($urandom_range(0, 3))
                    0:       period = 8'($urandom_range(0, 1));
                    1:       period = 8'd255;
                    default: period = 8'($urandom_range(2, 12));
                endcase
            end
            if (r >= 100 && r < 200) begin
                for (int ch = 0; ch < 2; ch++) begin
                    case ($urandom_range(0, 4))
                        0:       duty[ch*8 +: 8] = 8'd0;
                        1:       duty[ch*8 +: 8] = 8'd255;
                        default: duty[ch*8 +: 8] = 8'($urandom_range(0, 14));
                    endcase
                end
            end
            if (r >= 200 && r < 240) pol = 2'($urandom_range(0, 3));
            if (r >= 300 && r < 325) en = ~en;
            if (r == 999) begin
                #3 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            if (period == 8'd255) period = 8'd9;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
